clk_div_n: RTL and testbench

CLK_DIV_N -- requirements
Module: clk_div_n

---
 rtl/clk_div_n.sv | 101 ++++++++++
 tb/tb_clk_div_n.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider with 50% duty for odd and even divisors
module clk_div_n #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             period_tick,
  output logic             running
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] n_act;
  logic [WIDTH-1:0] n_pend;
  logic             pending;
  logic [WIDTH-1:0] cnt;
  logic             pos_q;
  logic             neg_q;

  logic             wrap;
  logic             period_start;
  logic             stop;
  logic             apply;
  logic             load_ok;
  logic             run_next;
  logic [WIDTH-1:0] n_next;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH:0]   half;
  logic             pos_next;

  always_comb begin
    wrap         = running && (cnt == (n_act - ONE));
    period_start = (!running && enable) || (wrap && enable);
    stop         = wrap && !enable;
    apply        = period_start && pending;
    n_next       = apply ? n_pend : n_act;
    run_next     = period_start || (running && !stop);
    load_ok      = div_load && (div_in >= TWO);

    if (period_start || stop)
      cnt_next = ZERO;
    else if (running)
      cnt_next = cnt + ONE;
    else
      cnt_next = cnt;

    // Half point uses the divisor of the period being entered, widened so 2^WIDTH-1 cannot wrap.
    half     = ({1'b0, n_next} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    pos_next = run_next && ({1'b0, cnt_next} < half);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_act       <= DIV_RESET;
      n_pend      <= DIV_RESET;
      pending     <= 1'b0;
      cnt         <= ZERO;
      pos_q       <= 1'b0;
      running     <= 1'b0;
      period_tick <= 1'b0;
      div_ack     <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      n_act       <= n_next;
      cnt         <= cnt_next;
      pos_q       <= pos_next;
      running     <= run_next;
      period_tick <= period_start;
      div_ack     <= apply;
      div_err     <= div_load && !load_ok;
      // A load on the applying edge becomes the next pending value.
      if (load_ok) begin
        n_pend  <= div_in;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n)
      neg_q <= 1'b0;
    else
      neg_q <= pos_q;
  end

  // Odd divisors trim the high phase by half a cycle via the falling-edge copy.
  assign clk_out = n_act[0] ? (pos_q & neg_q) : pos_q;

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - directed self-checking bench for clk_div_n
module tb_clk_div_n;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic       div_err;
  logic       clk_out;
  logic       period_tick;
  logic       running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_n #(.WIDTH(8), .RESET_DIV(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .div_in(div_in),
    .div_load(div_load), .div_ack(div_ack), .div_err(div_err),
    .clk_out(clk_out), .period_tick(period_tick), .running(running)
  );

  // Advance to the next rising-edge sample point, returning at a period_tick.
  task automatic wait_tick(output bit ok, output bit ack, output int cycles);
    ok = 0; ack = 0; cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      div_load = 0;
      cycles++;
      if (period_tick) begin
        ok = 1; ack = div_ack;
        break;
      end
    end
  endtask

  // Called at the sample point of a tick cycle; counts cycles and high half-cycles to the next tick.
  task automatic measure(output int per, output int hi, output bit ack_end);
    bit done;
    per = 1; hi = 0; ack_end = 0; done = 0;
    hi += int'(clk_out);
    @(negedge clk); #2;
    hi += int'(clk_out);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      div_load = 0;
      if (period_tick) begin
        ack_end = div_ack; done = 1;
        break;
      end
      per++;
      hi += int'(clk_out);
      @(negedge clk); #2;
      hi += int'(clk_out);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL measure_timeout per=%0d required tick", per);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (clk_out !== 1'b0)     begin errors++; $display("FAIL reset_clk_out got %b want 0", clk_out); end
    checks++; if (running !== 1'b0)     begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", period_tick); end
    checks++; if (div_ack !== 1'b0)     begin errors++; $display("FAIL reset_ack got %b want 0", div_ack); end
    checks++; if (div_err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", div_err); end
    @(negedge clk); #2;
    reset_n = 1;
  endtask

  task automatic test_default();
    bit ok, ack; int cyc, per, hi;
    enable = 1;
    wait_tick(ok, ack, cyc);
    checks++; if (!ok)              begin errors++; $display("FAIL start_tick got none want tick"); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
    measure(per, hi, ack);
    checks++; if (per != 3) begin errors++; $display("FAIL default_period got %0d want 3", per); end
    checks++; if (hi != 3)  begin errors++; $display("FAIL default_high_halves got %0d want 3", hi); end
  endtask

  task automatic test_loads();
    int seq [5] = '{4, 7, 255, 4, 5};
    int old_n, per, hi;
    bit ack;
    old_n = 3;
    foreach (seq[k]) begin
      div_in = 8'(seq[k]); div_load = 1;
      measure(per, hi, ack);
      checks++; if (per != old_n) begin errors++; $display("FAIL load%0d_old_period got %0d want %0d", seq[k], per, old_n); end
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL load%0d_ack got %b want 1", seq[k], ack); end
      measure(per, hi, ack);
      checks++; if (per != seq[k]) begin errors++; $display("FAIL load%0d_period got %0d want %0d", seq[k], per, seq[k]); end
      checks++; if (hi != seq[k])  begin errors++; $display("FAIL load%0d_high_halves got %0d want %0d", seq[k], hi, seq[k]); end
      checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL load%0d_spurious_ack got %b want 0", seq[k], ack); end
      old_n = seq[k];
    end
  endtask

  task automatic test_same_edge();
    int per, hi; bit ack;
    // Currently N=5, at the sample point of cnt=0; move to cnt=4 and load on the wrap edge.
    repeat (4) begin @(posedge clk); #2; end
    div_in = 8'd6; div_load = 1;
    @(posedge clk); #2;
    div_load = 0;
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL wrap_load_tick got %b want 1", period_tick); end
    checks++; if (div_ack !== 1'b0)     begin errors++; $display("FAIL wrap_load_early_ack got %b want 0", div_ack); end
    measure(per, hi, ack);
    checks++; if (per != 5)     begin errors++; $display("FAIL wrap_load_old_period got %0d want 5", per); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrap_load_ack got %b want 1", ack); end
    measure(per, hi, ack);
    checks++; if (per != 6) begin errors++; $display("FAIL wrap_load_period got %0d want 6", per); end
    checks++; if (hi != 6)  begin errors++; $display("FAIL wrap_load_high got %0d want 6", hi); end
  endtask

  task automatic test_err();
    bit ok, ack; int cyc, per, hi;
    int bad [2] = '{1, 0};
    foreach (bad[k]) begin
      div_in = 8'(bad[k]); div_load = 1;
      @(posedge clk); #2;
      div_load = 0;
      checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL err%0d_pulse got %b want 1", bad[k], div_err); end
      @(posedge clk); #2;
      checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL err%0d_width got %b want 0", bad[k], div_err); end
    end
    wait_tick(ok, ack, cyc);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL err_ack got %b want 0", ack); end
    measure(per, hi, ack);
    checks++; if (per != 6)     begin errors++; $display("FAIL err_period got %0d want 6", per); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL err_ack_end got %b want 0", ack); end
  endtask

  task automatic test_stop();
    int ticks, hi, per, cyc; bit ok, ack;
    // N=6, at cnt=0 sample point; drop enable during cnt=2.
    repeat (2) begin @(posedge clk); #2; end
    enable = 0;
    ticks = 0; hi = 0;
    repeat (20) begin
      @(negedge clk); #2;
      hi += int'(clk_out);
      @(posedge clk); #2;
      ticks += int'(period_tick);
      hi += int'(clk_out);
    end
    checks++; if (ticks != 0)       begin errors++; $display("FAIL stop_ticks got %0d want 0", ticks); end
    checks++; if (hi != 1)          begin errors++; $display("FAIL stop_tail_high got %0d want 1", hi); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running got %b want 0", running); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL stop_clk_out got %b want 0", clk_out); end
    enable = 1;
    @(posedge clk); #1;
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL restart_clk_out got %b want 1", clk_out); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart_running got %b want 1", running); end
    #1;
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL restart_tick got %b want 1", period_tick); end
    measure(per, hi, ack);
    checks++; if (per != 6) begin errors++; $display("FAIL restart_period got %0d want 6", per); end
    // Cancelled stop: drop at cnt=2, restore at cnt=4, next tick two cycles later.
    repeat (2) begin @(posedge clk); #2; end
    enable = 0;
    repeat (2) begin @(posedge clk); #2; end
    enable = 1;
    wait_tick(ok, ack, cyc);
    checks++; if (!ok || cyc != 2) begin errors++; $display("FAIL cancel_stop cycles got %0d want 2", cyc); end
  endtask

  task automatic test_reset_mid();
    bit ok, ack; int cyc, per, hi;
    div_in = 8'd5; div_load = 1;
    measure(per, hi, ack);
    // Now at the first tick of an N=5 period; clk_out rises half a cycle later.
    @(negedge clk); #2;
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL pre_reset_clk_out got %b want 1", clk_out); end
    reset_n = 0;
    #1;
    checks++; if (clk_out !== 1'b0)     begin errors++; $display("FAIL async_reset_clk_out got %b want 0", clk_out); end
    checks++; if (running !== 1'b0)     begin errors++; $display("FAIL async_reset_running got %b want 0", running); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL async_reset_tick got %b want 0", period_tick); end
    @(negedge clk); #2;
    reset_n = 1;
    wait_tick(ok, ack, cyc);
    checks++; if (!ok || ack !== 1'b0) begin errors++; $display("FAIL post_reset_start ok=%b ack=%b want 1 0", ok, ack); end
    measure(per, hi, ack);
    checks++; if (per != 3) begin errors++; $display("FAIL post_reset_period got %0d want 3", per); end
    checks++; if (hi != 3)  begin errors++; $display("FAIL post_reset_high got %0d want 3", hi); end
  endtask

  initial begin
    reset_n = 0; enable = 0; div_in = 8'd0; div_load = 0;
    test_reset();
    test_default();
    test_loads();
    test_same_edge();
    test_err();
    test_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
